floating_point_divider: RTL

Sequential IEEE-754 single-precision divider computing quotient = x / y with a restoring mantissa division, one quotient bit per cycle. It is the inverse-operation companion to the team's floating-point multiplier and sits beside it in the Multipliers/arithmetic group. It uses a start/done handshake and reports overflow and division-by-zero.

---
 rtl/floating_point_divider.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/floating_point_divider.sv
`default_nettype none
// floating_point_divider: sequential binary32 x / y using restoring mantissa division,
// one quotient bit per cycle, truncating rounding, start/done handshake.
module floating_point_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic        overflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_NORM   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [4:0]  c_LAST_ITER = 5'd24;
  localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;

  state_t             r_state;
  logic               r_sign;
  logic [23:0]        r_my;
  logic [24:0]        r_rem;
  logic [24:0]        r_q;
  logic [4:0]         r_cnt;
  logic signed [9:0]  r_exp;
  logic [31:0]        r_res;
  logic               r_res_ovf;
  logic               r_res_dbz;

  logic [7:0]         w_ex;
  logic [7:0]         w_ey;
  logic               w_sign;
  logic signed [9:0]  w_exp_diff;
  logic               w_ge;
  logic [24:0]        w_rem_sub;
  logic [24:0]        w_rem_next;
  logic signed [9:0]  w_norm_exp;
  logic [22:0]        w_norm_man;

  assign w_ex       = x[30:23];
  assign w_ey       = y[30:23];
  assign w_sign     = x[31] ^ y[31];
  assign w_exp_diff = $signed({2'b00, w_ex}) - $signed({2'b00, w_ey}) + 10'sd127;

  // The remainder stays below 2*my after every step, so 25 bits never overflow.
  assign w_ge       = (r_rem >= {1'b0, r_my});
  assign w_rem_sub  = w_ge ? (r_rem - {1'b0, r_my}) : r_rem;
  assign w_rem_next = w_rem_sub << 1;

  // Quotient of two [1,2) mantissas lies in (0.5,2): at most one left shift needed.
  assign w_norm_exp = r_q[24] ? r_exp : (r_exp - 10'sd1);
  assign w_norm_man = r_q[24] ? r_q[23:1] : r_q[22:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_sign      <= 1'b0;
      r_my        <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_exp       <= '0;
      r_res       <= '0;
      r_res_ovf   <= 1'b0;
      r_res_dbz   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            r_sign      <= w_sign;
            r_my        <= {1'b1, y[22:0]};
            r_rem       <= {2'b01, x[22:0]};
            r_q         <= '0;
            r_cnt       <= '0;
            r_exp       <= w_exp_diff;
            r_res_ovf   <= 1'b0;
            r_res_dbz   <= 1'b0;
            if (w_ex == 8'hFF || w_ey == 8'hFF) begin
              r_res   <= c_QNAN;
              r_state <= S_DONE;
            end else if (w_ex == 8'h00) begin
              r_res   <= {w_sign, 31'b0};
              r_state <= S_DONE;
            end else if (w_ey == 8'h00) begin
              r_res     <= {w_sign, 8'hFF, 23'b0};
              r_res_dbz <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_DIVIDE;
            end
          end
        end

        S_DIVIDE: begin
          r_q   <= {r_q[23:0], w_ge};
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == c_LAST_ITER) begin
            r_state <= S_NORM;
          end
        end

        S_NORM: begin
          r_res_dbz <= 1'b0;
          if (w_norm_exp > 10'sd254) begin
            r_res     <= {r_sign, 8'hFF, 23'b0};
            r_res_ovf <= 1'b1;
          end else if (w_norm_exp < 10'sd1) begin
            r_res     <= {r_sign, 31'b0};
            r_res_ovf <= 1'b0;
          end else begin
            r_res     <= {r_sign, w_norm_exp[7:0], w_norm_man};
            r_res_ovf <= 1'b0;
          end
          r_state <= S_DONE;
        end

        S_DONE: begin
          quotient    <= r_res;
          overflow    <= r_res_ovf;
          div_by_zero <= r_res_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
